// File: rtl/multiplier_controller.sv
// rtl/multiplier_controller.sv - sequencing FSM for the N-bit shift-add multiplier datapath
module multiplier_controller #(
  parameter int N  = 4,
  parameter int CW = $clog2(N)
) (
  input  logic          clock,
  input  logic          n_reset,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          do_init,
  output logic          do_shift,
  output logic          busy,
  output logic [CW-1:0] step
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state;

  localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

  // Accept from IDLE, or from DONE when the result is taken in the same cycle.
  // do_init is masked during reset so the datapath never loads while held.
  always_comb begin
    in_ready = (state == IDLE) | ((state == DONE) & out_ready);
    do_init  = in_valid & in_ready & n_reset;
  end

  // State, step counter and registered Moore outputs.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state     <= IDLE;
      step      <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      do_shift  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state    <= SHIFT;
            step     <= '0;
            do_shift <= 1'b1;
            busy     <= 1'b1;
          end
        end
        SHIFT: begin
          if (step == LAST_STEP) begin
            state     <= DONE;
            step      <= '0;
            do_shift  <= 1'b0;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end else begin
            step <= step + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              // back-to-back: next operation starts with no idle bubble
              state    <= SHIFT;
              step     <= '0;
              do_shift <= 1'b1;
              busy     <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state     <= IDLE;
          step      <= '0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          do_shift  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multiplier_controller.sv
// tb/tb_multiplier_controller.sv - directed self-checking bench for multiplier_controller
module tb_multiplier_controller;
  localparam int N = 4;

  logic       clock = 1'b0;
  logic       n_reset = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       in_ready, out_valid, do_init, do_shift, busy;
  logic [1:0] step;

  logic [3:0] mcand = 4'd0;
  logic [3:0] mplier = 4'd0;
  logic [3:0] mcand_l;
  logic [7:0] prod;
  logic [4:0] sum;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int shifts = 0;
  int inits = 0;

  multiplier_controller #(.N(N)) dut (
    .clock    (clock),
    .n_reset  (n_reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .do_init  (do_init),
    .do_shift (do_shift),
    .busy     (busy),
    .step     (step)
  );

  always #5 clock = ~clock;

  // Behavioural shift-add datapath driven by the controller strobes
  assign sum = {1'b0, prod[7:4]} + (prod[0] ? {1'b0, mcand_l} : 5'd0);

  always @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      prod    <= 8'd0;
      mcand_l <= 4'd0;
    end else if (do_init) begin
      prod    <= {4'd0, mplier};
      mcand_l <= mcand;
    end else if (do_shift) begin
      prod <= {sum, prod[3:1]};
    end
  end

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (do_shift) shifts <= shifts + 1;
    if (do_init) inits <= inits + 1;
  end

  task automatic next;
    @(posedge clock);
    #1;
  endtask

  task automatic sample;
    @(negedge clock);
  endtask

  task automatic test_reset;
    in_valid = 1'b1;
    #12;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b expected 1", in_ready); end
    checks++; if (do_init !== 1'b0) begin errors++; $display("FAIL reset_do_init got %0b expected 0", do_init); end
    checks++; if (do_shift !== 1'b0) begin errors++; $display("FAIL reset_do_shift got %0b expected 0", do_shift); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b expected 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b expected 0", busy); end
    checks++; if (step !== 2'd0) begin errors++; $display("FAIL reset_step got %0d expected 0", step); end
    checks++; if (prod !== 8'd0) begin errors++; $display("FAIL reset_product got %0d expected 0", prod); end
    in_valid = 1'b0;
    next;
    n_reset = 1'b1;
    next;
    sample;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_idle got in_ready=%0b out_valid=%0b expected 1 0", in_ready, out_valid); end
  endtask

  task automatic test_single;
    logic [7:0] exp_p [4];
    int s0;
    exp_p = '{8'h06, 8'h03, 8'h59, 8'h84};
    next;
    mcand = 4'd11; mplier = 4'd6; in_valid = 1'b1; out_ready = 1'b1;
    sample;
    s0 = shifts;
    checks++; if (do_init !== 1'b1 || in_ready !== 1'b1 || do_shift !== 1'b0) begin errors++; $display("FAIL single_accept got do_init=%0b in_ready=%0b do_shift=%0b expected 1 1 0", do_init, in_ready, do_shift); end
    next;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sample;
      checks++; if (do_shift !== 1'b1 || busy !== 1'b1 || do_init !== 1'b0) begin errors++; $display("FAIL single_shift%0d got do_shift=%0b busy=%0b do_init=%0b expected 1 1 0", i, do_shift, busy, do_init); end
      checks++; if (step !== 2'(i)) begin errors++; $display("FAIL single_step%0d got %0d expected %0d", i, step, i); end
      checks++; if (prod !== exp_p[i]) begin errors++; $display("FAIL single_partial%0d got %02h expected %02h", i, prod, exp_p[i]); end
      next;
    end
    sample;
    checks++; if (out_valid !== 1'b1 || busy !== 1'b0 || do_shift !== 1'b0) begin errors++; $display("FAIL single_done got out_valid=%0b busy=%0b do_shift=%0b expected 1 0 0", out_valid, busy, do_shift); end
    checks++; if (prod !== 8'd66) begin errors++; $display("FAIL single_product got %0d expected 66", prod); end
    checks++; if (shifts - s0 !== 4) begin errors++; $display("FAIL single_shift_count got %0d expected 4", shifts - s0); end
    checks++; if (step !== 2'd0) begin errors++; $display("FAIL single_done_step got %0d expected 0", step); end
    next;
    sample;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL single_idle got out_valid=%0b in_ready=%0b expected 0 1", out_valid, in_ready); end
  endtask

  task automatic test_backpressure;
    int s0, i0;
    next;
    mcand = 4'd15; mplier = 4'd15; in_valid = 1'b1; out_ready = 1'b0;
    sample;
    checks++; if (do_init !== 1'b1) begin errors++; $display("FAIL bp_accept got %0b expected 1", do_init); end
    next;
    in_valid = 1'b0;
    repeat (4) next;
    s0 = shifts; i0 = inits;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      sample;
      checks++; if (out_valid !== 1'b1 || prod !== 8'd225) begin errors++; $display("FAIL bp_hold%0d got out_valid=%0b product=%0d expected 1 225", i, out_valid, prod); end
      checks++; if (in_ready !== 1'b0 || do_init !== 1'b0 || do_shift !== 1'b0) begin errors++; $display("FAIL bp_quiet%0d got in_ready=%0b do_init=%0b do_shift=%0b expected 0 0 0", i, in_ready, do_init, do_shift); end
      next;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    sample;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %0b expected 1", in_ready); end
    checks++; if (shifts !== s0 || inits !== i0) begin errors++; $display("FAIL bp_no_strobes got shifts+%0d inits+%0d expected 0 0", shifts - s0, inits - i0); end
    next;
    sample;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_idle got out_valid=%0b busy=%0b in_ready=%0b expected 0 0 1", out_valid, busy, in_ready); end
  endtask

  task automatic test_back_to_back;
    int t1;
    next;
    mcand = 4'd3; mplier = 4'd5; in_valid = 1'b1; out_ready = 1'b1;
    sample;
    checks++; if (do_init !== 1'b1) begin errors++; $display("FAIL b2b_accept1 got %0b expected 1", do_init); end
    next;
    mcand = 4'd7; mplier = 4'd9;
    repeat (4) next;
    sample;
    t1 = cyc;
    checks++; if (out_valid !== 1'b1 || prod !== 8'd15) begin errors++; $display("FAIL b2b_result1 got out_valid=%0b product=%0d expected 1 15", out_valid, prod); end
    checks++; if (do_init !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("FAIL b2b_accept2 got do_init=%0b in_ready=%0b expected 1 1", do_init, in_ready); end
    next;
    in_valid = 1'b0;
    sample;
    checks++; if (do_shift !== 1'b1 || out_valid !== 1'b0 || step !== 2'd0) begin errors++; $display("FAIL b2b_no_bubble got do_shift=%0b out_valid=%0b step=%0d expected 1 0 0", do_shift, out_valid, step); end
    repeat (4) next;
    sample;
    checks++; if (out_valid !== 1'b1 || prod !== 8'd63) begin errors++; $display("FAIL b2b_result2 got out_valid=%0b product=%0d expected 1 63", out_valid, prod); end
    checks++; if (cyc - t1 !== 5) begin errors++; $display("FAIL b2b_spacing got %0d expected 5", cyc - t1); end
    next;
    sample;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle got %0b expected 0", out_valid); end
  endtask

  task automatic test_reset_mid;
    logic saw_valid;
    next;
    mcand = 4'd9; mplier = 4'd9; in_valid = 1'b1; out_ready = 1'b1;
    next;
    in_valid = 1'b0;
    next;
    sample;
    checks++; if (do_shift !== 1'b1 || step !== 2'd1) begin errors++; $display("FAIL rmid_second_shift got do_shift=%0b step=%0d expected 1 1", do_shift, step); end
    #2;
    n_reset = 1'b0;
    #1;
    checks++; if (do_shift !== 1'b0 || busy !== 1'b0 || step !== 2'd0) begin errors++; $display("FAIL rmid_async got do_shift=%0b busy=%0b step=%0d expected 0 0 0", do_shift, busy, step); end
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rmid_idle got out_valid=%0b in_ready=%0b expected 0 1", out_valid, in_ready); end
    next;
    next;
    n_reset = 1'b1;
    saw_valid = 1'b0;
    repeat (6) begin
      sample;
      if (out_valid) saw_valid = 1'b1;
      next;
    end
    checks++; if (saw_valid !== 1'b0) begin errors++; $display("FAIL rmid_no_result got %0b expected 0", saw_valid); end
    mcand = 4'd2; mplier = 4'd13; in_valid = 1'b1;
    sample;
    checks++; if (do_init !== 1'b1) begin errors++; $display("FAIL rmid_reaccept got %0b expected 1", do_init); end
    next;
    in_valid = 1'b0;
    repeat (4) next;
    sample;
    checks++; if (out_valid !== 1'b1 || prod !== 8'd26) begin errors++; $display("FAIL rmid_product got out_valid=%0b product=%0d expected 1 26", out_valid, prod); end
    next;
  endtask

  task automatic test_ignore;
    int s0, i0;
    mcand = 4'd3; mplier = 4'd3; in_valid = 1'b1; out_ready = 1'b1;
    sample;
    next;
    s0 = shifts; i0 = inits;
    for (int i = 0; i < 4; i++) begin
      in_valid = (i % 2 == 0) ? 1'b1 : 1'b0;
      sample;
      checks++; if (do_init !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL ign_init%0d got do_init=%0b in_ready=%0b expected 0 0", i, do_init, in_ready); end
      checks++; if (do_shift !== 1'b1 || step !== 2'(i)) begin errors++; $display("FAIL ign_step%0d got do_shift=%0b step=%0d expected 1 %0d", i, do_shift, step, i); end
      next;
    end
    in_valid = 1'b0;
    sample;
    checks++; if (out_valid !== 1'b1 || prod !== 8'd9) begin errors++; $display("FAIL ign_product got out_valid=%0b product=%0d expected 1 9", out_valid, prod); end
    checks++; if (shifts - s0 !== 4 || inits !== i0) begin errors++; $display("FAIL ign_counts got shifts=%0d inits+%0d expected 4 0", shifts - s0, inits - i0); end
    next;
    sample;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL ign_idle got out_valid=%0b busy=%0b expected 0 0", out_valid, busy); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_backpressure;
    test_back_to_back;
    test_reset_mid;
    test_ignore;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multiplier_controller.md
Name: multiplier_controller

Overview:
Sequencing FSM for multiplier_datapath, the N-bit shift-add multiplier.
- Accepts an operand-valid handshake and strobes do_init once.
- Strobes do_shift for exactly N consecutive cycles.
- Presents the finished product under a valid/ready output handshake.
- Carries no operand or product data. It sits beside the datapath and drives that block's do_init/do_shift pins directly.

Parameters:
N, 4, datapath width in bits and number of shift steps; legal range N >= 2
CW, $clog2(N), width of step counter (derived, not overridden)

Ports:
clock  input  1  system clock, rising edge active
n_reset  input  1  asynchronous reset, active low
in_valid  input  1  multiplicand/multiplier present and stable
in_ready  output  1  controller accepts an operation this cycle
out_valid  output  1  datapath product holds a completed result
out_ready  input  1  consumer takes the result this cycle
do_init  output  1  to datapath: load product={0,multiplier}
do_shift  output  1  to datapath: perform one add/shift step
busy  output  1  high while in state SHIFT
step  output  CW  index of the current shift step, 0..N-1

Behaviour:
Reset and decided interface:
- One clock; reset is asynchronous and active-low, port names clock and n_reset.
- While n_reset=0: state=IDLE, step=0, out_valid=0, busy=0, do_shift=0, do_init=0. in_ready follows the IDLE rule.
- Reset mid-operation: outputs return to reset values immediately, without waiting for a clock edge. The partial result is discarded and no out_valid is produced.

States: IDLE, SHIFT, DONE (registered state, Moore outputs except do_init and in_ready).

IDLE:
- in_ready=1.
- If in_valid=1: do_init=1 combinationally (accept = in_valid & in_ready). Next state SHIFT, step<=0.
- Otherwise remain in IDLE with no strobes.

SHIFT:
- do_shift=1, busy=1, in_ready=0.
- Each edge: step<=step+1. When step==N-1, next state DONE and step<=0.
- in_valid and out_ready are ignored.
- Exactly N do_shift cycles are issued per operation, never more or fewer.

DONE:
- out_valid=1, do_shift=0.
- out_ready=0: hold DONE indefinitely. The product is stable because no strobes are issued.
- out_ready=1 and in_valid=0: next state IDLE.
- out_ready=1 and in_valid=1: the result is consumed and the new operation accepted in the same cycle. in_ready=1 and do_init=1, next state SHIFT (back-to-back, no idle bubble).
- in_ready = (state==IDLE) | (state==DONE & out_ready).

Timing and rules:
- Latency: the accept edge is A. do_shift is high during cycles A+1..A+N. out_valid rises after edge A+N, so product is correct N+1 edges after acceptance.
- Throughput: one result per N+1 cycles when out_ready is held high.
- Operands must remain stable only during the accept cycle; the datapath latches them on do_init.
- do_init and do_shift are never high in the same cycle.
- busy and out_valid are never high together.
- step is 0 outside SHIFT.

Test Plan:
- Reset: n_reset=0 with in_valid=1 -> in_ready=1, do_init=0, do_shift=0, out_valid=0; the datapath product reads 0.
- Single op with the datapath, N=4: multiplicand=11, multiplier=6, one-cycle in_valid, out_ready=1. Check:
  - do_init high for 1 cycle, then do_shift high for exactly 4 cycles.
  - step sequence 0,1,2,3.
  - Intermediate products {0,6}, {0,3}, {5,9}, {8,4}.
  - out_valid rises with product=66, then returns to IDLE.
- Output backpressure: 15×15 with out_ready=0 for 10 cycles -> out_valid held, product=225 stable, in_ready=0, no strobes. Raise out_ready -> IDLE next cycle.
- Back-to-back: in_valid=1 continuously with 3×5 then 7×9, out_ready=1. The second op is accepted in the DONE cycle of the first. Check results 15 then 63, with 5 cycles between out_valid pulses.
- Reset mid-op: deassert n_reset during the 2nd shift cycle -> do_shift falls immediately, state IDLE, out_valid never asserted. The next op 2×13 yields 26.
- Idle/ignore: in_valid toggled while busy -> no do_init and no extra shifts; the step count is unaffected.
